// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat while a key is held).
package keypad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam logic [NUM_COLS-1:0] COL_IDLE = 4'b1111;

  typedef enum logic [1:0] {
    SCAN,
    CONFIRM,
    EMIT,
    WAIT_RELEASE
  } state_e;

  typedef struct packed {
    logic [1:0] row_idx;
    logic [1:0] col_idx;
  } key_code_t;

  // Index of the lowest-numbered row that reads low; callers ensure one exists.
  function automatic logic [1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows_n);
    logic [1:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_ROWS; i++) begin
      if (!rows_n[i] && !found) begin
        idx   = i[1:0];
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  // Active-low one-hot-zero strobe for a column index.
  function automatic logic [NUM_COLS-1:0] col_strobe(input logic [1:0] idx);
    return COL_IDLE & ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/keypad_dwell_timer.sv
// Dwell counter for the keypad scanner: counts 0..SCAN_DIV-1 and flags the
// last cycle of each dwell, which is when the scanner samples its rows.
// Optional feature macro: KEYPAD_REPEAT_EN (not used in this file).
module keypad_dwell_timer
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic clock,
  input  logic reset_n,
  output logic sample_stb
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: wrap to zero after the last cycle of a dwell.
  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  // Dwell counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign sample_stb = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes columns, synchronises and debounces the
// row returns, and hands one key code per press over valid/ready.
// Optional feature macro: KEYPAD_REPEAT_EN enables auto-repeat of a held key
// every REPEAT_PERIOD dwells; without it REPEAT_PERIOD is unused.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV      = 1000,
  parameter int unsigned STABLE_COUNT  = 4,
  parameter int unsigned REPEAT_PERIOD = 250
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic       key_valid,
  input  logic       key_ready,
  output logic [3:0] key_code,
  output logic       key_pressed
);

  if (SCAN_DIV < 4 || STABLE_COUNT < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("keypad_scanner: SCAN_DIV must be >= 4, STABLE_COUNT and REPEAT_PERIOD >= 1");
  end

  localparam int unsigned SCW = $clog2(STABLE_COUNT + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(STABLE_COUNT - 1);

  logic            sample_stb;
  logic [3:0]      sync1_q, sync2_q;
  state_e          state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [1:0]      row_q, row_d;
  logic [SCW-1:0]  stab_q, stab_d;
  logic            valid_q, valid_d;
  key_code_t       code_q, code_d;
  logic            pressed_q, pressed_d;
  logic            row_low;
`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RPW = $clog2(REPEAT_PERIOD + 1);
  localparam logic [RPW-1:0] RP_LAST = RPW'(REPEAT_PERIOD - 1);
  logic [RPW-1:0]  rep_q, rep_d;
`endif

  keypad_dwell_timer #(
    .SCAN_DIV(SCAN_DIV)
  ) u_dwell (
    .clock     (clock),
    .reset_n   (reset_n),
    .sample_stb(sample_stb)
  );

  // State register plus synchroniser and datapath flops.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      state_q   <= SCAN;
      col_q     <= '0;
      row_q     <= '0;
      stab_q    <= '0;
      valid_q   <= 1'b0;
      code_q    <= '0;
      pressed_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      sync1_q   <= row_n;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      stab_q    <= stab_d;
      valid_q   <= valid_d;
      code_q    <= code_d;
      pressed_q <= pressed_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  // Next-state and datapath: all row decisions happen on the dwell's last cycle.
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    stab_d    = stab_q;
    valid_d   = valid_q;
    code_d    = code_q;
    pressed_d = pressed_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d     = rep_q;
`endif
    row_low   = ~sync2_q[row_q];
    case (state_q)
      SCAN: begin
        if (sample_stb) begin
          if (~&sync2_q) begin
            row_d   = lowest_low_row(sync2_q);
            stab_d  = '0;
            state_d = CONFIRM;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
      end
      CONFIRM: begin
        if (sample_stb) begin
          if (row_low) begin
            if (stab_q == SC_LAST) begin
              code_d.row_idx = row_q;
              code_d.col_idx = col_q;
              valid_d   = 1'b1;
              pressed_d = 1'b1;
              stab_d    = '0;
              state_d   = EMIT;
            end else begin
              stab_d = stab_q + SCW'(1);
            end
          end else begin
            col_d   = col_q + 2'd1;
            state_d = SCAN;
          end
        end
      end
      EMIT: begin
        if (key_ready) begin
          valid_d = 1'b0;
          stab_d  = '0;
          state_d = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (sample_stb) begin
          if (!row_low) begin
            if (stab_q == SC_LAST) begin
              pressed_d = 1'b0;
              stab_d    = '0;
              col_d     = col_q + 2'd1;
              state_d   = SCAN;
            end else begin
              stab_d = stab_q + SCW'(1);
            end
`ifdef KEYPAD_REPEAT_EN
            rep_d = '0;
`endif
          end else begin
            stab_d = '0;
`ifdef KEYPAD_REPEAT_EN
            // Re-enter EMIT with the unchanged code once the held key has
            // been seen for a full repeat period.
            if (rep_q == RP_LAST) begin
              rep_d   = '0;
              valid_d = 1'b1;
              state_d = EMIT;
            end else begin
              rep_d = rep_q + RPW'(1);
            end
`endif
          end
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // Outputs come straight from registers.
  always_comb begin
    col_n       = col_strobe(col_q);
    key_valid   = valid_q;
    key_code    = code_q;
    key_pressed = pressed_q;
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a physical keypad model drives the
// rows from the strobed columns; directed scenarios plus randomised presses
// are checked against expectations derived from key position and timing rules.
// Optional feature macro: KEYPAD_REPEAT_EN adds an auto-repeat interval check.
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV      = 4;
  localparam int unsigned STABLE_COUNT  = 2;
  localparam int unsigned REPEAT_PERIOD = 3;
  localparam int unsigned LATENCY       = (STABLE_COUNT + 1) * SCAN_DIV + 2;
  localparam int unsigned SCAN_ROUND    = 4 * SCAN_DIV;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_code;
  logic       key_pressed;
  logic [3:0] key_row [4];

  int unsigned checks   = 0;
  int unsigned failures = 0;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .STABLE_COUNT (STABLE_COUNT),
    .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .row_n      (row_n),
    .col_n      (col_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_code   (key_code),
    .key_pressed(key_pressed)
  );

  always #5 clock = ~clock;

  // Keypad matrix: a row reads low when a held key on it sits in a strobed column.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++) row_n[r] = ~|(key_row[r] & ~col_n);
  end

  // Protocol monitor: strobe shape, event count, and hold-until-handshake.
  int unsigned rises = 0, onehot_err = 0, hold_err = 0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [3:0]  prev_code  = '0;
  always @(negedge clock) begin
    if (reset_n) begin
      if ($countones(~col_n) != 1) onehot_err <= onehot_err + 1;
      if (prev_valid && !prev_ready && (!key_valid || key_code != prev_code)) hold_err <= hold_err + 1;
      if (prev_valid && prev_ready && key_valid) hold_err <= hold_err + 1;
      if (key_valid && !prev_valid) rises <= rises + 1;
      prev_valid <= key_valid;
    end else begin
      prev_valid <= 1'b0;
    end
    prev_ready <= key_ready;
    prev_code  <= key_code;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_keys();
    for (int i = 0; i < 4; i++) key_row[i] = '0;
  endtask

  // Returns just after the edge on which col_n switches to the wanted strobe.
  task automatic wait_col(input logic [3:0] want, output bit ok);
    int unsigned n;
    n = 0;
    while (col_n == want && n < 64) begin tick(1); n++; end
    while (col_n != want && n < 64) begin tick(1); n++; end
    ok = (col_n == want);
  endtask

  task automatic wait_valid(input int unsigned bound, output int unsigned cycles, output bit ok);
    ok = 1'b0;
    cycles = 0;
    while (cycles < bound && !ok) begin
      tick(1);
      cycles++;
      if (key_valid) ok = 1'b1;
    end
  endtask

  task automatic wait_release(input int unsigned bound, output bit ok);
    int unsigned n;
    n = 0;
    while (key_pressed && n < bound) begin tick(1); n++; end
    ok = !key_pressed;
  endtask

  initial begin
    bit          ok;
    int unsigned cyc;
    int unsigned base;
    logic [3:0]  exp_col;
    logic [3:0]  seen;

    reset_n   = 1'b0;
    key_ready = 1'b0;
    clear_keys();
    tick(2);
    check_eq("rst_col_n", col_n, 4'b1110);
    check_eq("rst_valid", key_valid, 0);
    check_eq("rst_code", key_code, 0);
    check_eq("rst_pressed", key_pressed, 0);

    // Idle scan: strobe index advances once per SCAN_DIV cycles.
    @(negedge clock);
    reset_n = 1'b1;
    for (int unsigned k = 0; k <= 16; k++) begin
      if (k != 0) begin @(posedge clock); #1; end
      exp_col = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      check_eq($sformatf("scan_k%0d", k), col_n, exp_col);
    end

    // Row1 pressed on column 2: bounded latency, code {1,2}, then handshake.
    base = rises;
    wait_col(4'b1011, ok);
    check_eq("t2_col_reach", ok, 1);
    key_row[1] = 4'b0100;
    wait_valid(LATENCY, cyc, ok);
    check_eq("t2_latency", ok, 1);
    check_eq("t2_code", key_code, 4'b0110);
    check_eq("t2_pressed", key_pressed, 1);
    key_ready = 1'b1;
    tick(1);
    check_eq("t2_valid_drop", key_valid, 0);
    key_ready = 1'b0;
    clear_keys();
    wait_release(64, ok);
    check_eq("t2_release", ok, 1);
    check_eq("t2_events", rises - base, 1);

    // Bounce: row0 seen for a single sample only.
    base = rises;
    wait_col(4'b1110, ok);
    check_eq("t3_col_reach", ok, 1);
    key_row[0] = 4'b0001;
    tick(5);
    clear_keys();
    seen = '0;
    for (int unsigned i = 0; i < 40; i++) begin
      tick(1);
      seen = seen | ~col_n;
    end
    check_eq("t3_events", rises - base, 0);
    check_eq("t3_pressed", key_pressed, 0);
    check_eq("t3_rotating", seen, 4'hF);

    // Held key with consumer stalled; release during EMIT keeps the event.
    base = rises;
    key_row[3] = 4'b0001;
    wait_valid(SCAN_ROUND + LATENCY + SCAN_DIV, cyc, ok);
    check_eq("t4_valid", ok, 1);
    check_eq("t4_code", key_code, 4'b1100);
    tick(20);
    clear_keys();
    tick(20);
    check_eq("t4_still_valid", key_valid, 1);
    check_eq("t4_code_stable", key_code, 4'b1100);
    key_ready = 1'b1;
    tick(1);
    check_eq("t4_valid_drop", key_valid, 0);
    key_ready = 1'b0;
    wait_release(64, ok);
    check_eq("t4_release", ok, 1);
    check_eq("t4_events", rises - base, 1);

    // Two rows low on the same column: lowest row wins, one event.
    base = rises;
    key_row[1] = 4'b0010;
    key_row[2] = 4'b0010;
    wait_valid(SCAN_ROUND + LATENCY + SCAN_DIV, cyc, ok);
    check_eq("t5_valid", ok, 1);
    check_eq("t5_code", key_code, 4'b0101);
    key_ready = 1'b1;
    tick(1);
    check_eq("t5_valid_drop", key_valid, 0);
    tick(8);
    clear_keys();
    wait_release(64, ok);
    key_ready = 1'b0;
    check_eq("t5_release", ok, 1);
    check_eq("t5_events", rises - base, 1);

    // Reset while an event is pending clears everything asynchronously.
    key_row[0] = 4'b0100;
    wait_valid(SCAN_ROUND + LATENCY + SCAN_DIV, cyc, ok);
    check_eq("t6_valid", ok, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("t6_async_valid", key_valid, 0);
    check_eq("t6_async_col", col_n, 4'b1110);
    check_eq("t6_async_pressed", key_pressed, 0);
    check_eq("t6_async_code", key_code, 0);
    clear_keys();
    tick(2);
    @(negedge clock);
    reset_n = 1'b1;
    base = rises;
    tick(3 * SCAN_ROUND);
    check_eq("t6_dropped", rises - base, 0);
    check_eq("t6_no_valid", key_valid, 0);

`ifdef KEYPAD_REPEAT_EN
    // Held key with ready high re-emits once per REPEAT_PERIOD dwells.
    key_ready  = 1'b1;
    key_row[2] = 4'b1000;
    wait_valid(SCAN_ROUND + LATENCY + SCAN_DIV, cyc, ok);
    check_eq("rep_first", ok, 1);
    cyc = 0;
    while (key_valid && cyc < 100) begin tick(1); cyc++; end
    while (!key_valid && cyc < 100) begin tick(1); cyc++; end
    check_eq("rep_interval", cyc, REPEAT_PERIOD * SCAN_DIV);
    check_eq("rep_code", key_code, 4'b1011);
    clear_keys();
    wait_release(100, ok);
    check_eq("rep_release", ok, 1);
    key_ready = 1'b0;
    tick(SCAN_DIV);
`endif

    // Randomised presses: one or two rows on a random column.
    for (int unsigned t = 0; t < 16; t++) begin
      int unsigned c, r0, r1, two, early_rel;
      logic [3:0]  mask;
      logic [1:0]  exp_row;
      logic        found;
      c         = $urandom_range(0, 3);
      r0        = $urandom_range(0, 3);
      r1        = $urandom_range(0, 3);
      two       = $urandom_range(0, 1);
      early_rel = $urandom_range(0, 1);
      mask      = 4'b0001 << r0;
      if (two != 0) mask = mask | (4'b0001 << r1);
      exp_row = '0;
      found   = 1'b0;
      for (int unsigned r = 0; r < 4; r++) begin
        if (mask[r] && !found) begin
          exp_row = r[1:0];
          found   = 1'b1;
        end
      end
      base = rises;
      tick($urandom_range(0, 7));
      for (int unsigned r = 0; r < 4; r++) if (mask[r]) key_row[r] = 4'b0001 << c;
      wait_valid(SCAN_ROUND + LATENCY + SCAN_DIV, cyc, ok);
      check_eq($sformatf("rnd%0d_valid", t), ok, 1);
      check_eq($sformatf("rnd%0d_code", t), key_code, {exp_row, c[1:0]});
      if (early_rel != 0) clear_keys();
      tick($urandom_range(0, 12));
      check_eq($sformatf("rnd%0d_hold", t), key_valid, 1);
      key_ready = 1'b1;
      tick(1);
      check_eq($sformatf("rnd%0d_drop", t), key_valid, 0);
      if (early_rel == 0) begin
        tick($urandom_range(0, 20));
        clear_keys();
      end
      wait_release(64, ok);
      check_eq($sformatf("rnd%0d_release", t), ok, 1);
`ifndef KEYPAD_REPEAT_EN
      check_eq($sformatf("rnd%0d_events", t), rises - base, 1);
`endif
      key_ready = 1'b0;
      tick(SCAN_DIV);
    end

    check_eq("mon_onehot", onehot_err, 0);
    check_eq("mon_hold", hold_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
